// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu. The ALU side uses the slave modport.
// Handshake: a request is taken on a rising edge where start=1 and busy=0; busy stays high
// until the edge after the one-cycle done pulse, and results hold until the next done.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, opcode, input_a, input_b,
        input  result_lo, result_hi, busy, done, div_by_zero
    );

    modport slave (
        input  start, opcode, input_a, input_b,
        output result_lo, result_hi, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: one-cycle logic/arith/shift ops, iterative signed MUL (Booth) and DIV.
// Define ALU_SEQ_BOOTH4_EN to retire 2 multiplier bits per cycle (radix-4 Booth).
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       clear,
    seq_alu_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam int SW = $clog2(WIDTH);
    localparam int AW = WIDTH + 2;
`ifdef ALU_SEQ_BOOTH4_EN
    localparam int MUL_ITER = WIDTH / 2;
`else
    localparam int MUL_ITER = WIDTH;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SHRA = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;

    logic [1:0]       state_q, state_d;
    logic             is_div_q, is_div_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             qbit_q, qbit_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0]   a, b, a_mag, b_mag, simple_lo;
    logic [SW-1:0]      shamt;
    logic [2*WIDTH-1:0] rol_w, ror_w;

    assign a     = bus.input_a;
    assign b     = bus.input_b;
    assign shamt = b[SW-1:0];
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    always_comb begin
        rol_w = {a, a} << shamt;
        ror_w = {a, a} >> shamt;
        case (bus.opcode)
            OP_OR:   simple_lo = a | b;
            OP_AND:  simple_lo = a & b;
            OP_NOT:  simple_lo = ~a;
            OP_ADD:  simple_lo = a + b;
            OP_SUB:  simple_lo = a - b;
            OP_NEG:  simple_lo = -a;
            OP_SHL:  simple_lo = a << shamt;
            OP_SHR:  simple_lo = a >> shamt;
            OP_SHRA: simple_lo = $signed(a) >>> shamt;
            OP_ROL:  simple_lo = rol_w[2*WIDTH-1:WIDTH];
            OP_ROR:  simple_lo = ror_w[WIDTH-1:0];
            default: simple_lo = '0;
        endcase
    end

    // Booth step: accumulator is two bits wider than the operand so +/-2M never overflows.
    logic [AW-1:0]             m_ext, booth_sum;
    logic [AW+WIDTH-1:0]       booth_full;
    logic signed [AW+WIDTH-1:0] booth_shr;
    logic [AW-1:0]             mul_acc_n;
    logic [WIDTH-1:0]          mul_mq_n;
    logic                      mul_qbit_n;

    always_comb begin
        m_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
`ifdef ALU_SEQ_BOOTH4_EN
        case ({mq_q[1:0], qbit_q})
            3'b001, 3'b010: booth_sum = acc_q + m_ext;
            3'b011:         booth_sum = acc_q + {m_ext[AW-2:0], 1'b0};
            3'b100:         booth_sum = acc_q - {m_ext[AW-2:0], 1'b0};
            3'b101, 3'b110: booth_sum = acc_q - m_ext;
            default:        booth_sum = acc_q;
        endcase
        booth_full = {booth_sum, mq_q};
        booth_shr  = $signed(booth_full) >>> 2;
        mul_qbit_n = mq_q[1];
`else
        case ({mq_q[0], qbit_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        booth_full = {booth_sum, mq_q};
        booth_shr  = $signed(booth_full) >>> 1;
        mul_qbit_n = mq_q[0];
`endif
        mul_acc_n = booth_shr[AW+WIDTH-1:WIDTH];
        mul_mq_n  = booth_shr[WIDTH-1:0];
    end

    // Restoring division on magnitudes; signs are applied on the last step.
    logic [WIDTH:0]   rem_sh, trial, rem_n;
    logic [WIDTH-1:0] div_mq_n;

    always_comb begin
        rem_sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, mcand_q};
        if (!trial[WIDTH]) begin
            rem_n    = trial;
            div_mq_n = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n    = rem_sh;
            div_mq_n = {mq_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        qbit_d   = qbit_q;
        mcand_d  = mcand_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dz_d  = 1'b0;
                    acc_d = '0;
                    if (bus.opcode == OP_MUL) begin
                        is_div_d = 1'b0;
                        mcand_d  = a;
                        mq_d     = b;
                        qbit_d   = 1'b0;
                        cnt_d    = SW'(MUL_ITER - 1);
                        state_d  = S_RUN;
                    end else if (bus.opcode == OP_DIV && b == '0) begin
                        lo_d    = '1;
                        hi_d    = a;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (bus.opcode == OP_DIV) begin
                        is_div_d = 1'b1;
                        mcand_d  = b_mag;
                        mq_d     = a_mag;
                        qneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        rneg_d   = a[WIDTH-1];
                        cnt_d    = SW'(WIDTH - 1);
                        state_d  = S_RUN;
                    end else begin
                        lo_d    = simple_lo;
                        hi_d    = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = {1'b0, rem_n};
                    mq_d  = div_mq_n;
                end else begin
                    acc_d  = mul_acc_n;
                    mq_d   = mul_mq_n;
                    qbit_d = mul_qbit_n;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (is_div_q) begin
                        lo_d = qneg_q ? -div_mq_n : div_mq_n;
                        hi_d = rneg_q ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
                    end else begin
                        lo_d = mul_mq_n;
                        hi_d = mul_acc_n[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            qbit_q   <= 1'b0;
            mcand_q  <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            qbit_q   <= qbit_d;
            mcand_q  <= mcand_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.result_lo   = lo_q;
    assign bus.result_hi   = hi_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = dz_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); MUL latency follows ALU_SEQ_BOOTH4_EN.
module tb_seq_alu;
    localparam int W = 32;
`ifdef ALU_SEQ_BOOTH4_EN
    localparam int MUL_LAT = W / 2 + 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic       clock;
    logic       clear;
    logic [1:0] state_dbg;
    int         n_cmp;
    int         n_err;
    logic [2*W-1:0] exp_q[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver: one request, then wait for done; inputs are scrambled after capture
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp, input int exp_lat,
                          input logic exp_dz);
        int lat;
        exp_q.push_back(exp);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.opcode  = op;
        bus.input_a = a;
        bus.input_b = b;
        @(posedge clock);
        #1;
        bus.start   = 1'b0;
        bus.opcode  = 4'($urandom_range(0, 15));
        bus.input_a = $urandom;
        bus.input_b = $urandom;
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check($sformatf("%s_lat", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s_res", tag), {bus.result_hi, bus.result_lo}, exp_q.pop_front());
        check($sformatf("%s_dz", tag), 64'(bus.div_by_zero), 64'(exp_dz));
        @(posedge clock);
        #1;
        check($sformatf("%s_idle", tag), {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        int n_done;
        logic [2*W-1:0] seen;
        n_cmp = 0;
        n_err = 0;
        clear = 1'b1;
        bus.start   = 1'b0;
        bus.opcode  = 4'd0;
        bus.input_a = '0;
        bus.input_b = '0;
        #12;
        check("reset_outs", {bus.result_hi, bus.result_lo}, 64'd0);
        check("reset_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        #11 clear = 1'b0;

        run_op("add", 4'd3, 32'd20, 32'd5, 64'd25, 1, 1'b0);
        run_op("add_wrap", 4'd3, 32'hFFFF_FFFF, 32'd2, 64'd1, 1, 1'b0);
        run_op("or", 4'd0, 32'h0000_F0F0, 32'h0000_0FF0, 64'h0000_FFF0, 1, 1'b0);
        run_op("and", 4'd1, 32'h0000_F0F0, 32'h0000_0FF0, 64'h0000_00F0, 1, 1'b0);
        run_op("not", 4'd2, 32'h1234_5678, 32'd0, 64'hEDCB_A987, 1, 1'b0);
        run_op("sub", 4'd4, 32'd5, 32'd20, 64'hFFFF_FFF1, 1, 1'b0);
        run_op("neg", 4'd5, 32'd1, 32'd0, 64'hFFFF_FFFF, 1, 1'b0);
        run_op("shl", 4'd8, 32'd1, 32'h21, 64'd2, 1, 1'b0);
        run_op("shr", 4'd9, 32'h8000_0000, 32'd31, 64'd1, 1, 1'b0);
        run_op("shr0", 4'd9, 32'hDEAD_BEEF, 32'h20, 64'hDEAD_BEEF, 1, 1'b0);
        run_op("rol", 4'd11, 32'h8000_0001, 32'h41, 64'h3, 1, 1'b0);
        run_op("op14", 4'd14, 32'd5, 32'd5, 64'd0, 1, 1'b0);

        run_op("mul_neg", 4'd6, -32'sd6, 32'd7, 64'hFFFF_FFFF_FFFF_FFD6, MUL_LAT, 1'b0);
        run_op("mul_min", 4'd6, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_LAT, 1'b0);
        run_op("mul_minm1", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, MUL_LAT, 1'b0);
        run_op("mul_max", 4'd6, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, MUL_LAT, 1'b0);
        run_op("mul_mix", 4'd6, 32'd12345, -32'sd1000, 64'hFFFF_FFFF_FF43_A158, MUL_LAT, 1'b0);

        run_op("div_neg", 4'd7, -32'sd20, 32'd6, 64'hFFFF_FFFE_FFFF_FFFD, DIV_LAT, 1'b0);
        run_op("div_min", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_LAT, 1'b0);
        run_op("div_pos", 4'd7, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DIV_LAT, 1'b0);
        run_op("div_negb", 4'd7, 32'd7, -32'sd2, 64'h0000_0001_FFFF_FFFD, DIV_LAT, 1'b0);
        run_op("div_zero", 4'd7, 32'd20, 32'd0, 64'h0000_0014_FFFF_FFFF, 1, 1'b1);
        run_op("add_clr_dz", 4'd3, 32'd1, 32'd1, 64'd2, 1, 1'b0);

        // start re-pulsed during a MUL is dropped, not queued
        @(negedge clock);
        bus.start = 1'b1; bus.opcode = 4'd6; bus.input_a = 32'd1000; bus.input_b = 32'd1000;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n_done = 0;
        seen = '0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            if (bus.done) begin
                n_done++;
                seen = {bus.result_hi, bus.result_lo};
                check("busy_mul_lat", 64'(cyc), 64'(MUL_LAT));
            end
            if (cyc == 4) begin
                @(negedge clock);
                bus.start = 1'b1; bus.opcode = 4'd3; bus.input_a = 32'd9; bus.input_b = 32'd9;
            end
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        check("busy_done_cnt", 64'(n_done), 64'd1);
        check("busy_mul_res", seen, 64'h0000_0000_000F_4240);
        check("busy_hold", {bus.result_hi, bus.result_lo}, 64'h0000_0000_000F_4240);

        // asynchronous clear in the middle of a DIV
        @(negedge clock);
        bus.start = 1'b1; bus.opcode = 4'd7; bus.input_a = 32'd100000; bus.input_b = 32'd7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        clear = 1'b1;
        #1;
        check("clr_outs", {bus.result_hi, bus.result_lo}, 64'd0);
        check("clr_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        run_op("ror", 4'd12, 32'h0000_00B2, 32'd2, 64'h8000_002C, 1, 1'b0);
        run_op("shra", 4'd10, 32'h8000_0000, 32'h24, 64'hF800_0000, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
